dcache_data_ram_mw: RTL and testbench

Multi-way data RAM for the data cache, with byte-column writes from the CPU side. Adds a beat-serial line-fill port (refill from memory) and a beat-serial eviction port (line read-out to the victim cache / write-back path). It sits between the dcache controller, the memory refill interface and the victim buffer. One FSM serialises CPU, fill and evict access to the storage.

---
 rtl/dcache_data_pkg.sv | 17 +
 rtl/dcache_data_ram_mw_bank.sv | 26 ++
 rtl/dcache_data_ram_mw.sv | 187 ++++++++++++++++++
 tb/tb_dcache_data_ram_mw.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dcache_data_pkg.sv
// dcache_data_pkg: shared defaults, FSM state encoding and column parity helper for the dcache data RAM.
package dcache_data_pkg;
  localparam int NUM_SETS_DEF = 2048;
  localparam int NUM_COL_DEF = 16;
  localparam int COL_WIDTH_DEF = 8;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_FILL_WR,
    ST_EVICT_RD,
    ST_EVICT
  } dcache_data_state_e;
  // XOR reduction; a zero-extended column gives its even-parity bit
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/dcache_data_ram_mw_bank.sv
// dcache_data_bank: one way of byte-column storage, write-first per column, registered 1-cycle read.
module dcache_data_bank #(
  parameter int NUM_SETS = 2048,
  parameter int NUM_COL = 16,
  parameter int CW = 8,
  localparam int AW = $clog2(NUM_SETS)
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic [NUM_COL-1:0]    we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [NUM_COL*CW-1:0] wdata_i,
  output logic [NUM_COL*CW-1:0] rdata_o
);
  logic [NUM_COL*CW-1:0] mem_q [NUM_SETS];
  logic [NUM_COL*CW-1:0] rdata_q;
  always_ff @(posedge clk)
    if (en_i)
      for (int c = 0; c < NUM_COL; c++)
        if (we_i[c]) begin
          mem_q[addr_i][c*CW +: CW] <= wdata_i[c*CW +: CW];
          rdata_q[c*CW +: CW] <= wdata_i[c*CW +: CW];
        end else
          rdata_q[c*CW +: CW] <= mem_q[addr_i][c*CW +: CW];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/dcache_data_ram_mw.sv
// dcache_data_ram_mw: multi-way dcache data RAM with CPU column writes, beat-serial fill and evict ports.
// Define DCACHE_DATA_PARITY_EN to store and check one even-parity bit per column.
module dcache_data_ram_mw
  import dcache_data_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int NUM_SETS = NUM_SETS_DEF,
  parameter int NUM_COL = NUM_COL_DEF,
  parameter int COL_WIDTH = COL_WIDTH_DEF,
  parameter int BEAT_WIDTH = 32,
  localparam int LINE_WIDTH = NUM_COL * COL_WIDTH,
  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH,
  localparam int ADDR_W = $clog2(NUM_SETS),
  localparam int WAY_W = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1,
  localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [NUM_COL-1:0]    wr_en_i,
  input  logic [WAY_W-1:0]      way_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [LINE_WIDTH-1:0] wdata_i,
  output logic [LINE_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  input  logic                  fill_start_i,
  input  logic [WAY_W-1:0]      fill_way_i,
  input  logic [ADDR_W-1:0]     fill_addr_i,
  input  logic                  fill_valid_i,
  input  logic [BEAT_WIDTH-1:0] fill_data_i,
  output logic                  fill_ready_o,
  output logic                  fill_done_o,
  input  logic                  evict_start_i,
  input  logic [WAY_W-1:0]      evict_way_i,
  input  logic [ADDR_W-1:0]     evict_addr_i,
  output logic                  evict_valid_o,
  output logic [BEAT_WIDTH-1:0] evict_data_o,
  input  logic                  evict_ready_i,
  output logic                  evict_done_o,
  output logic                  busy_o,
  output logic                  parity_err_o
);
`ifdef DCACHE_DATA_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int CW = COL_WIDTH + PB;
  localparam int LW = NUM_COL * CW;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  dcache_data_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WAY_W-1:0] fill_way_q, evict_way_q, rd_way_q, sel_way;
  logic [ADDR_W-1:0] fill_addr_q, evict_addr_q, bank_addr;
  logic [LINE_WIDTH-1:0] fill_buf_q, evict_buf_q, rdata_hold_q, bank_line, sel_line;
  logic rvalid_q, evict_perr_q;
  logic [NUM_WAYS-1:0] bank_en;
  logic [NUM_COL-1:0] bank_we;
  logic [LW-1:0] bank_wdata, sel_raw;
  logic [LW-1:0] bank_rdata [NUM_WAYS];

  assign gnt_o = req_i & (state_q == ST_IDLE) & ~evict_start_i & ~fill_start_i;
  assign busy_o = state_q != ST_IDLE;
  assign fill_ready_o = state_q == ST_FILL;
  assign fill_done_o = state_q == ST_FILL_WR;
  assign evict_valid_o = state_q == ST_EVICT;
  assign evict_done_o = evict_valid_o & evict_ready_i & (cnt_q == LAST);
  assign evict_data_o = evict_buf_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH];
  assign rvalid_o = rvalid_q;
  assign rdata_o = rvalid_q ? sel_line : rdata_hold_q;
  assign sel_way = state_q == ST_EVICT_RD ? evict_way_q : rd_way_q;
  assign sel_raw = bank_rdata[sel_way];

  // Eviction read is launched in the start cycle so EVICT_RD sees bank data
  always_comb begin
    bank_en = '0;
    bank_we = '0;
    bank_addr = addr_i;
    bank_line = wdata_i;
    if (gnt_o) begin
      bank_en[way_i] = 1'b1;
      bank_we = wr_en_i;
    end else if (state_q == ST_IDLE && evict_start_i) begin
      bank_en[evict_way_i] = 1'b1;
      bank_addr = evict_addr_i;
    end else if (state_q == ST_FILL_WR) begin
      bank_en[fill_way_q] = 1'b1;
      bank_we = '1;
      bank_addr = fill_addr_q;
      bank_line = fill_buf_q;
    end
  end

`ifdef DCACHE_DATA_PARITY_EN
  logic [NUM_COL-1:0] col_err, wmask_q;
  assign parity_err_o = (rvalid_q & |(col_err & ~wmask_q)) | evict_perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
`ifdef DCACHE_DATA_PARITY_EN
    assign bank_wdata[c*CW +: CW] = {even_par(64'(bank_line[c*COL_WIDTH +: COL_WIDTH])),
                                     bank_line[c*COL_WIDTH +: COL_WIDTH]};
    assign col_err[c] = even_par(64'(sel_raw[c*CW +: CW]));
`else
    assign bank_wdata[c*CW +: CW] = bank_line[c*COL_WIDTH +: COL_WIDTH];
`endif
    assign sel_line[c*COL_WIDTH +: COL_WIDTH] = sel_raw[c*CW +: COL_WIDTH];
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    dcache_data_bank #(
      .NUM_SETS(NUM_SETS),
      .NUM_COL (NUM_COL),
      .CW      (CW)
    ) u_bank (
      .clk    (clk),
      .en_i   (bank_en[w]),
      .we_i   (bank_we),
      .addr_i (bank_addr),
      .wdata_i(bank_wdata),
      .rdata_o(bank_rdata[w])
    );
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      fill_way_q <= '0;
      fill_addr_q <= '0;
      evict_way_q <= '0;
      evict_addr_q <= '0;
      rd_way_q <= '0;
      fill_buf_q <= '0;
      evict_buf_q <= '0;
      rdata_hold_q <= '0;
      rvalid_q <= 1'b0;
      evict_perr_q <= 1'b0;
`ifdef DCACHE_DATA_PARITY_EN
      wmask_q <= '0;
`endif
    end else begin
      rvalid_q <= gnt_o;
      evict_perr_q <= 1'b0;
      if (gnt_o) rd_way_q <= way_i;
`ifdef DCACHE_DATA_PARITY_EN
      if (gnt_o) wmask_q <= wr_en_i;
`endif
      if (rvalid_q) rdata_hold_q <= sel_line;
      case (state_q)
        ST_IDLE:
          if (evict_start_i) begin
            state_q <= ST_EVICT_RD;
            evict_way_q <= evict_way_i;
            evict_addr_q <= evict_addr_i;
          end else if (fill_start_i) begin
            state_q <= ST_FILL;
            fill_way_q <= fill_way_i;
            fill_addr_q <= fill_addr_i;
          end
        ST_FILL:
          if (fill_valid_i) begin
            fill_buf_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= fill_data_i;
            cnt_q <= cnt_q == LAST ? '0 : cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= ST_FILL_WR;
          end
        ST_FILL_WR: state_q <= ST_IDLE;
        ST_EVICT_RD: begin
          evict_buf_q <= sel_line;
`ifdef DCACHE_DATA_PARITY_EN
          evict_perr_q <= |col_err;
`endif
          state_q <= ST_EVICT;
        end
        ST_EVICT:
          if (evict_ready_i) begin
            cnt_q <= cnt_q == LAST ? '0 : cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= ST_IDLE;
          end
        default: state_q <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_dcache_data_ram_mw.sv
// tb_dcache_data_ram_mw: directed self-checking bench for dcache_data_ram_mw (default parameters).
module tb_dcache_data_ram_mw;
  logic clk = 1'b0, rst = 1'b1;
  logic req_i = 0, gnt_o;
  logic [15:0] wr_en_i = '0;
  logic [0:0] way_i = '0, fill_way_i = '0, evict_way_i = '0;
  logic [10:0] addr_i = '0, fill_addr_i = '0, evict_addr_i = '0;
  logic [127:0] wdata_i = '0, rdata_o;
  logic rvalid_o;
  logic fill_start_i = 0, fill_valid_i = 0, fill_ready_o, fill_done_o;
  logic [31:0] fill_data_i = '0, evict_data_o;
  logic evict_start_i = 0, evict_valid_o, evict_ready_i = 0, evict_done_o;
  logic busy_o, parity_err_o;
  int n_cmp = 0, n_fail = 0;

  localparam logic [127:0] L55 = {16{8'h55}};
  localparam logic [127:0] LMIX = {{8{8'h55}}, {8{8'hAA}}};
  localparam logic [127:0] LFILL = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  dcache_data_ram_mw dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .wr_en_i(wr_en_i), .way_i(way_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .fill_start_i(fill_start_i), .fill_way_i(fill_way_i), .fill_addr_i(fill_addr_i),
    .fill_valid_i(fill_valid_i), .fill_data_i(fill_data_i), .fill_ready_o(fill_ready_o),
    .fill_done_o(fill_done_o), .evict_start_i(evict_start_i), .evict_way_i(evict_way_i),
    .evict_addr_i(evict_addr_i), .evict_valid_o(evict_valid_o), .evict_data_o(evict_data_o),
    .evict_ready_i(evict_ready_i), .evict_done_o(evict_done_o), .busy_o(busy_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    n_cmp++; if ({busy_o, rvalid_o, fill_ready_o, fill_done_o, evict_valid_o, evict_done_o, parity_err_o, gnt_o} !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got %b want 00000000", {busy_o, rvalid_o, fill_ready_o, fill_done_o, evict_valid_o, evict_done_o, parity_err_o, gnt_o}); end
    n_cmp++; if (rdata_o !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
    n_cmp++; if (evict_data_o !== '0) begin n_fail++; $display("FAIL reset_evict_data: got %h want 0", evict_data_o); end
    rst = 0;
    step();
  endtask

  task automatic test_cpu_access();
    req_i = 1; way_i = 1; addr_i = 5; wr_en_i = 16'hFFFF; wdata_i = L55;
    #1;
    n_cmp++; if (gnt_o !== 1'b1) begin n_fail++; $display("FAIL cpu_gnt: got %b want 1", gnt_o); end
    step();
    req_i = 0; wr_en_i = '0;
    n_cmp++; if (rvalid_o !== 1'b1 || rdata_o !== L55) begin n_fail++; $display("FAIL cpu_full_wr: got v=%b %h want v=1 %h", rvalid_o, rdata_o, L55); end
    req_i = 1; wr_en_i = 16'h00FF; wdata_i = {16{8'hAA}};
    step();
    req_i = 0; wr_en_i = '0;
    n_cmp++; if (rvalid_o !== 1'b1 || rdata_o !== LMIX) begin n_fail++; $display("FAIL cpu_col_wr_first: got v=%b %h want v=1 %h", rvalid_o, rdata_o, LMIX); end
    step();
    n_cmp++; if (rvalid_o !== 1'b0 || rdata_o !== LMIX) begin n_fail++; $display("FAIL cpu_hold: got v=%b %h want v=0 %h", rvalid_o, rdata_o, LMIX); end
    req_i = 1; wdata_i = '0;
    step();
    req_i = 0;
    n_cmp++; if (rvalid_o !== 1'b1 || rdata_o !== LMIX) begin n_fail++; $display("FAIL cpu_read: got v=%b %h want v=1 %h", rvalid_o, rdata_o, LMIX); end
  endtask

  task automatic test_fill();
    fill_start_i = 1; fill_way_i = 0; fill_addr_i = 7;
    step();
    fill_start_i = 0;
    n_cmp++; if (busy_o !== 1'b1 || fill_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_enter: got busy=%b rdy=%b want 1 1", busy_o, fill_ready_o); end
    for (int k = 0; k < 4; k++) begin
      fill_valid_i = 0;
      step();
      n_cmp++; if (fill_done_o !== 1'b0) begin n_fail++; $display("FAIL fill_done_early: got %b want 0 (beat %0d)", fill_done_o, k); end
      fill_valid_i = 1; fill_data_i = 32'h03020100 + 32'(k) * 32'h04040404;
      step();
    end
    fill_valid_i = 0;
    n_cmp++; if (fill_done_o !== 1'b1 || fill_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_done: got done=%b rdy=%b want 1 0", fill_done_o, fill_ready_o); end
    step();
    n_cmp++; if (fill_done_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL fill_idle: got done=%b busy=%b want 0 0", fill_done_o, busy_o); end
    req_i = 1; way_i = 0; addr_i = 7; wr_en_i = '0;
    step();
    req_i = 0;
    n_cmp++; if (rdata_o !== LFILL) begin n_fail++; $display("FAIL fill_readback: got %h want %h", rdata_o, LFILL); end
  endtask

  task automatic test_evict_stall();
    logic [31:0] exp [4];
    exp = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    evict_start_i = 1; evict_way_i = 0; evict_addr_i = 7; evict_ready_i = 0;
    step();
    evict_start_i = 0;
    n_cmp++; if (busy_o !== 1'b1 || evict_valid_o !== 1'b0) begin n_fail++; $display("FAIL evict_rd: got busy=%b v=%b want 1 0", busy_o, evict_valid_o); end
    step();
    n_cmp++; if (evict_valid_o !== 1'b1 || evict_data_o !== exp[0]) begin n_fail++; $display("FAIL evict_beat0: got v=%b %h want 1 %h", evict_valid_o, evict_data_o, exp[0]); end
    evict_ready_i = 1;
    step();
    evict_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (evict_valid_o !== 1'b1 || evict_data_o !== exp[1]) begin n_fail++; $display("FAIL evict_stall: got v=%b %h want 1 %h", evict_valid_o, evict_data_o, exp[1]); end
    end
    evict_ready_i = 1;
    for (int b = 1; b < 4; b++) begin
      n_cmp++; if (evict_data_o !== exp[b] || evict_done_o !== (b == 3)) begin n_fail++; $display("FAIL evict_beat%0d: got %h done=%b want %h done=%b", b, evict_data_o, evict_done_o, exp[b], b == 3); end
      step();
    end
    evict_ready_i = 0;
    n_cmp++; if (busy_o !== 1'b0 || evict_valid_o !== 1'b0 || evict_done_o !== 1'b0) begin n_fail++; $display("FAIL evict_end: got busy=%b v=%b done=%b want 0 0 0", busy_o, evict_valid_o, evict_done_o); end
  endtask

  task automatic test_priority();
    evict_start_i = 1; evict_way_i = 0; evict_addr_i = 7;
    fill_start_i = 1; fill_way_i = 1; fill_addr_i = 9;
    req_i = 1; way_i = 1; addr_i = 5;
    #1;
    n_cmp++; if (gnt_o !== 1'b0) begin n_fail++; $display("FAIL prio_gnt: got %b want 0", gnt_o); end
    step();
    evict_start_i = 0; fill_start_i = 0; req_i = 0;
    n_cmp++; if (busy_o !== 1'b1 || fill_ready_o !== 1'b0 || rvalid_o !== 1'b0) begin n_fail++; $display("FAIL prio_evict_wins: got busy=%b frdy=%b rv=%b want 1 0 0", busy_o, fill_ready_o, rvalid_o); end
    fill_start_i = 1;
    step();
    n_cmp++; if (evict_valid_o !== 1'b1 || evict_data_o !== 32'h03020100) begin n_fail++; $display("FAIL prio_evict_beat0: got v=%b %h want 1 03020100", evict_valid_o, evict_data_o); end
    evict_ready_i = 1;
    for (int i = 0; i < 20 && busy_o; i++) step();
    fill_start_i = 0; evict_ready_i = 0;
    n_cmp++; if (busy_o !== 1'b0 || fill_ready_o !== 1'b0) begin n_fail++; $display("FAIL prio_drain: got busy=%b frdy=%b want 0 0", busy_o, fill_ready_o); end
  endtask

  task automatic test_reset_mid_fill();
    fill_start_i = 1; fill_way_i = 0; fill_addr_i = 7;
    step();
    fill_start_i = 0; fill_valid_i = 1; fill_data_i = 32'hDEADBEEF;
    repeat (2) step();
    fill_valid_i = 0;
    rst = 1;
    #1;
    n_cmp++; if (busy_o !== 1'b0 || fill_ready_o !== 1'b0 || fill_done_o !== 1'b0) begin n_fail++; $display("FAIL midfill_abort: got busy=%b rdy=%b done=%b want 0 0 0", busy_o, fill_ready_o, fill_done_o); end
    step();
    rst = 0;
    step();
    n_cmp++; if (fill_done_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL midfill_no_done: got done=%b busy=%b want 0 0", fill_done_o, busy_o); end
    req_i = 1; way_i = 0; addr_i = 7; wr_en_i = '0;
    step();
    req_i = 0;
    n_cmp++; if (rdata_o !== LFILL) begin n_fail++; $display("FAIL midfill_old_data: got %h want %h", rdata_o, LFILL); end
  endtask

  task automatic test_parity();
`ifdef DCACHE_DATA_PARITY_EN
    dut.g_way[0].u_bank.mem_q[7][27] = ~dut.g_way[0].u_bank.mem_q[7][27];
`endif
    req_i = 1; way_i = 0; addr_i = 7; wr_en_i = '0;
    step();
    req_i = 0;
`ifdef DCACHE_DATA_PARITY_EN
    n_cmp++; if (rvalid_o !== 1'b1 || parity_err_o !== 1'b1) begin n_fail++; $display("FAIL parity_err: got v=%b perr=%b want 1 1", rvalid_o, parity_err_o); end
`else
    n_cmp++; if (rvalid_o !== 1'b1 || parity_err_o !== 1'b0) begin n_fail++; $display("FAIL parity_off: got v=%b perr=%b want 1 0", rvalid_o, parity_err_o); end
`endif
    step();
    n_cmp++; if (parity_err_o !== 1'b0) begin n_fail++; $display("FAIL parity_pulse: got %b want 0", parity_err_o); end
  endtask

  initial begin
    test_reset();
    test_cpu_access();
    test_fill();
    test_evict_stall();
    test_priority();
    test_reset_mid_fill();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
